// File: rtl/lpf_pkg.sv
// Shared constants and types for the multi-channel leaky-integrator scheduler.
package lpf_pkg;

    localparam int LPF_NUM_CH        = 4;
    localparam int LPF_IN_WIDTH      = 16;
    localparam int LPF_OUT_WIDTH     = 16;
    localparam int LPF_MAX_SHIFT     = 15;
    localparam int LPF_ACC_W         = LPF_IN_WIDTH + LPF_MAX_SHIFT + 1;
    localparam int LPF_OUT_SHIFT     = 8;
    localparam int LPF_MAX_OUT       = 32767;
    localparam int LPF_MIN_OUT       = -32768;
    localparam int LPF_DEFAULT_SHIFT = 4;
    localparam int LPF_SHIFT_W       = 4;
    localparam int LPF_CH_W          = $clog2(LPF_NUM_CH);

    typedef logic [LPF_CH_W-1:0] ch_idx_t;

    // Limit a requested decay shift to the largest value the accumulator can absorb.
    function automatic logic [LPF_SHIFT_W-1:0] cap_shift(input logic [LPF_SHIFT_W-1:0] req,
                                                          input int maxShift);
        if (int'(req) > maxShift) begin
            return LPF_SHIFT_W'(maxShift);
        end
        return req;
    endfunction

endpackage

// File: rtl/lpf_sat_shift.sv
// Accumulator-to-output scaling: arithmetic right shift followed by a symmetric clamp.
module lpf_sat_shift
    import lpf_pkg::*;
#(
    parameter int ACC_W   = LPF_ACC_W,
    parameter int OUT_W   = LPF_OUT_WIDTH,
    parameter int SHIFT   = LPF_OUT_SHIFT,
    parameter int MAX_OUT = LPF_MAX_OUT,
    parameter int MIN_OUT = LPF_MIN_OUT
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] sat
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(MAX_OUT);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(MIN_OUT);

    logic signed [ACC_W-1:0] shifted;

    // Shift first so the clamp limits are expressed in output units.
    always_comb begin
        shifted = acc >>> SHIFT;
        if (shifted > HI) begin
            sat = OUT_W'(HI);
        end else if (shifted < LO) begin
            sat = OUT_W'(LO);
        end else begin
            sat = OUT_W'(shifted);
        end
    end

endmodule

// File: rtl/lpf_channel_scheduler.sv
// Round-robin scheduler feeding NUM_CH requesters through one shared leaky integrator.
// Each accepted sample updates that channel's accumulator; the scaled, clamped result
// is presented one cycle later with its channel index.
module lpf_channel_scheduler
    import lpf_pkg::*;
#(
    parameter int NUM_CH        = LPF_NUM_CH,
    parameter int IN_WIDTH      = LPF_IN_WIDTH,
    parameter int OUT_WIDTH     = LPF_OUT_WIDTH,
    parameter int MAX_SHIFT     = LPF_MAX_SHIFT,
    parameter int OUT_SHIFT     = LPF_OUT_SHIFT,
    parameter int MAX_OUT       = LPF_MAX_OUT,
    parameter int MIN_OUT       = LPF_MIN_OUT,
    parameter int DEFAULT_SHIFT = LPF_DEFAULT_SHIFT,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic                        clkIn,
    input  logic                        resetN,
    input  logic [NUM_CH-1:0]           inValid,
    input  logic [NUM_CH*IN_WIDTH-1:0]  inData,
    output logic [NUM_CH-1:0]           inReady,
    input  logic                        cfgWe,
    input  logic [CH_W-1:0]             cfgChannel,
    input  logic [LPF_SHIFT_W-1:0]      cfgShift,
    input  logic                        cfgClear,
    output logic                        outValid,
    output logic [CH_W-1:0]             outChannel,
    output logic signed [OUT_WIDTH-1:0] outData
);

    localparam int ACC_W = IN_WIDTH + MAX_SHIFT + 1;

    logic signed [ACC_W-1:0]    acc [NUM_CH];
    logic [LPF_SHIFT_W-1:0]     shift [NUM_CH];
    logic [CH_W-1:0]            lastGrant;

    logic [NUM_CH-1:0]          clearMask;
    logic [NUM_CH-1:0]          eligible;
    logic [NUM_CH-1:0]          grant;
    logic [CH_W-1:0]            grantIdx;
    logic [CH_W-1:0]            probe;
    logic                       grantFound;

    logic signed [IN_WIDTH-1:0] sample;
    logic signed [ACC_W-1:0]    accCur;
    logic signed [ACC_W-1:0]    accNext;
    logic signed [OUT_WIDTH-1:0] satData;
    logic [LPF_SHIFT_W-1:0]     shiftCapped;

    // Round-robin grant; a channel being cleared this cycle is skipped so the
    // clear and an update never collide on the same accumulator.
    always_comb begin
        clearMask = '0;
        if (cfgWe && cfgClear) begin
            clearMask[cfgChannel] = 1'b1;
        end
        eligible   = inValid & ~clearMask & {NUM_CH{resetN}};
        grant      = '0;
        grantIdx   = '0;
        grantFound = 1'b0;
        probe      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            probe = CH_W'((int'(lastGrant) + k) % NUM_CH);
            if (!grantFound && eligible[probe]) begin
                grantFound      = 1'b1;
                grant[probe]    = 1'b1;
                grantIdx        = probe;
            end
        end
    end

    assign inReady = grant;

    // Leaky-integrator step for the granted channel: acc + x - acc/2^shift.
    always_comb begin
        accCur  = acc[grantIdx];
        sample  = inData[int'(grantIdx)*IN_WIDTH +: IN_WIDTH];
        accNext = accCur + ACC_W'(sample) - (accCur >>> shift[grantIdx]);
    end

    assign shiftCapped = cap_shift(cfgShift, MAX_SHIFT);

    lpf_sat_shift #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_WIDTH),
        .SHIFT   (OUT_SHIFT),
        .MAX_OUT (MAX_OUT),
        .MIN_OUT (MIN_OUT)
    ) u_sat (
        .acc (accNext),
        .sat (satData)
    );

    // Per-channel state: config writes and clears, plus the single accumulator update.
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]   <= '0;
                shift[i] <= LPF_SHIFT_W'(DEFAULT_SHIFT);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfgWe && int'(cfgChannel) == i) begin
                    shift[i] <= shiftCapped;
                end
                if (cfgWe && cfgClear && int'(cfgChannel) == i) begin
                    acc[i] <= '0;
                end else if (grantFound && int'(grantIdx) == i) begin
                    acc[i] <= accNext;
                end
            end
        end
    end

    // Arbiter pointer and registered result strobe; data and channel hold when idle.
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            lastGrant  <= CH_W'(NUM_CH - 1);
            outValid   <= 1'b0;
            outChannel <= '0;
            outData    <= '0;
        end else begin
            outValid <= grantFound;
            if (grantFound) begin
                lastGrant  <= grantIdx;
                outChannel <= grantIdx;
                outData    <= satData;
            end
        end
    end

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Randomized self-checking bench with a behavioural model of the scheduler.
module tb_lpf_channel_scheduler;

    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int OSH = 2;
    localparam int MXO = 1000;
    localparam int MNO = -1000;
    localparam int DSH = 2;

    logic                  clkIn = 1'b0;
    logic                  resetN = 1'b0;
    logic [NCH-1:0]        inValid;
    logic [NCH*IW-1:0]     inData;
    logic [NCH-1:0]        inReady;
    logic                  cfgWe;
    logic [1:0]            cfgChannel;
    logic [3:0]            cfgShift;
    logic                  cfgClear;
    logic                  outValid;
    logic [1:0]            outChannel;
    logic signed [15:0]    outData;

    always #5 clkIn = ~clkIn;

    lpf_channel_scheduler #(
        .NUM_CH(NCH), .IN_WIDTH(IW), .OUT_WIDTH(16), .MAX_SHIFT(15),
        .OUT_SHIFT(OSH), .MAX_OUT(MXO), .MIN_OUT(MNO), .DEFAULT_SHIFT(DSH)
    ) dut (
        .clkIn(clkIn), .resetN(resetN), .inValid(inValid), .inData(inData),
        .inReady(inReady), .cfgWe(cfgWe), .cfgChannel(cfgChannel),
        .cfgShift(cfgShift), .cfgClear(cfgClear), .outValid(outValid),
        .outChannel(outChannel), .outData(outData)
    );

    int n_pass = 0;
    int n_total = 0;
    bit checking = 0;

    // Model state (current = what DUT registers hold now, nxt = after next edge)
    longint m_acc [NCH];
    longint x_acc [NCH];
    int     m_shift [NCH];
    int     x_shift [NCH];
    int     m_last, x_last;
    bit     m_ov, x_ov;
    int     m_och, x_och;
    longint m_od, x_od;
    logic [NCH-1:0] exp_ready;

    // Stimulus for the next step
    logic [NCH-1:0]     s_valid;
    logic signed [15:0] s_data [NCH];
    bit                 s_we, s_clr;
    int                 s_ch, s_sh;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic longint fdiv(input longint a, input int s);
        longint d;
        d = longint'(1) << s;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic longint clampv(input longint v);
        if (v > MXO) return MXO;
        if (v < MNO) return MNO;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0; x_acc[i] = 0; m_shift[i] = DSH; x_shift[i] = DSH;
        end
        m_last = NCH - 1; x_last = NCH - 1;
        m_ov = 0; x_ov = 0; m_och = 0; x_och = 0; m_od = 0; x_od = 0;
        exp_ready = '0;
    endtask

    task automatic commit();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = x_acc[i]; m_shift[i] = x_shift[i];
        end
        m_last = x_last; m_ov = x_ov; m_och = x_och; m_od = x_od;
    endtask

    task automatic predict();
        int g;
        longint na;
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (g < 0 && s_valid[c] && !(s_we && s_clr && s_ch == c)) g = c;
        end
        for (int i = 0; i < NCH; i++) begin
            x_acc[i] = m_acc[i]; x_shift[i] = m_shift[i];
        end
        x_last = m_last; x_och = m_och; x_od = m_od;
        exp_ready = '0;
        if (g >= 0) begin
            na = m_acc[g] + longint'(s_data[g]) - fdiv(m_acc[g], m_shift[g]);
            x_acc[g] = na;
            x_last = g; x_ov = 1; x_och = g;
            x_od = clampv(fdiv(na, OSH));
            exp_ready[g] = 1'b1;
        end else begin
            x_ov = 0;
        end
        if (s_we) begin
            x_shift[s_ch] = (s_sh > 15) ? 15 : s_sh;
            if (s_clr) x_acc[s_ch] = 0;
        end
    endtask

    task automatic idle_stim();
        s_valid = '0; s_we = 0; s_clr = 0; s_ch = 0; s_sh = 0;
        for (int i = 0; i < NCH; i++) s_data[i] = '0;
    endtask

    task automatic drive();
        inValid = s_valid;
        for (int i = 0; i < NCH; i++) inData[i*IW +: IW] = s_data[i];
        cfgWe = s_we; cfgClear = s_clr;
        cfgChannel = 2'(s_ch); cfgShift = 4'(s_sh);
    endtask

    // One clock: commit the edge that just happened, then apply new stimulus.
    task automatic step();
        @(posedge clkIn); #1;
        commit();
        drive();
        predict();
        #1;
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clkIn) begin
        if (checking) begin
            chk("inReady", longint'(inReady), longint'(exp_ready));
            chk("outValid", longint'(outValid), longint'(m_ov));
            chk("outChannel", longint'(outChannel), longint'(m_och));
            chk("outData", longint'(outData), m_od);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_stim();
        s_valid = '1;
        drive();
        model_reset();
        #1;
        checking = 1;
        chk("rst_inReady", longint'(inReady), 0);
        chk("rst_outValid", longint'(outValid), 0);
        chk("rst_outData", longint'(outData), 0);
        chk("rst_outChannel", longint'(outChannel), 0);
        @(posedge clkIn); #1;
        idle_stim(); drive();
        @(posedge clkIn); #3;
        resetN = 1'b1;

        // Channel 0 constant 100 alone: 25, 43, 58 ...
        idle_stim();
        s_valid = 4'b0001; s_data[0] = 16'sd100;
        step(); step();
        chk("c0_first", longint'(outData), 25);
        chk("c0_first_ch", longint'(outChannel), 0);
        step();
        chk("c0_second", longint'(outData), 43);
        idle_stim(); step();
        chk("c0_third", longint'(outData), 58);
        chk("c0_valid", longint'(outValid), 1);

        // All channels requesting: grants rotate 1,2,3,0,... after last grant 0
        s_valid = '1;
        for (int k = 0; k < 8; k++) begin
            s_data[k % NCH] = 16'(k * 11);
            step();
            chk("rr_grant", longint'(inReady), longint'(4'b0001 << ((k + 1) % NCH)));
        end

        // Shift 0 on channel 1 gives pass-through
        idle_stim(); s_we = 1; s_ch = 1; s_sh = 0; step();
        idle_stim(); s_valid = 4'b0010; s_data[1] = -16'sd7; step();
        idle_stim(); step();
        chk("pass_through", longint'(outData), -2);

        // Saturation at MAX_OUT on channel 2 with shift 4
        idle_stim(); s_we = 1; s_ch = 2; s_sh = 4; step();
        idle_stim(); s_valid = 4'b0100; s_data[2] = 16'sd32767;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k > 0) chk("sat_limit", longint'(outData <= 16'sd1000), 1);
        end
        idle_stim(); step();
        chk("sat_value", longint'(outData), 1000);

        // Clear on channel 3 while it requests
        idle_stim(); s_valid = 4'b1000; s_data[3] = 16'sd500;
        repeat (3) step();
        s_valid = 4'b1001; s_data[0] = 16'sd3;
        s_we = 1; s_clr = 1; s_ch = 3; s_sh = 2;
        step();
        chk("clr_ready3", longint'(inReady[3]), 0);
        chk("clr_ready0", longint'(inReady[0]), 1);
        idle_stim(); s_valid = 4'b1000; s_data[3] = 16'sd40; step();
        idle_stim(); step();
        chk("clr_next", longint'(outData), 10);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            idle_stim();
            s_valid = 4'($urandom);
            for (int i = 0; i < NCH; i++) s_data[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                s_we = 1; s_ch = $urandom_range(0, 3); s_sh = $urandom_range(0, 15);
                s_clr = $urandom_range(0, 1) == 1;
            end
            step();
        end

        // Reset mid-stream with a result pending
        idle_stim(); s_valid = '1; s_data[0] = 16'sd9; step();
        @(posedge clkIn); #1;
        commit();
        chk("pre_rst_valid", longint'(outValid), 1);
        #1;
        resetN = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", longint'(outValid), 0);
        chk("mid_rst_ready", longint'(inReady), 0);
        repeat (2) @(posedge clkIn);
        #3;
        idle_stim(); drive();
        resetN = 1'b1;
        idle_stim(); s_valid = 4'b0001; s_data[0] = 16'sd100; step();
        idle_stim(); step();
        chk("post_rst", longint'(outData), 25);
        step();

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
